// File: rtl/csr_access_unit_pkg.sv
// Shared CSR definitions: datapath widths, Zicsr funct3 encodings, the implemented
// machine-mode CSR address map and its compaction into CSR-file indices.
package csr_access_unit_pkg;

    localparam int XLEN      = 64;
    localparam int CSR_IDX_W = 4;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef struct packed {
        logic                 valid;
        logic [CSR_IDX_W-1:0] idx;
    } csr_idx_t;

    function automatic csr_idx_t csr_index(input logic [11:0] addr);
        csr_idx_t r;
        r.valid = 1'b1;
        r.idx   = '0;
        case (addr)
            CSR_MSTATUS:   r.idx = CSR_IDX_W'(0);
            CSR_MISA:      r.idx = CSR_IDX_W'(1);
            CSR_MIE:       r.idx = CSR_IDX_W'(2);
            CSR_MTVEC:     r.idx = CSR_IDX_W'(3);
            CSR_MSCRATCH:  r.idx = CSR_IDX_W'(4);
            CSR_MEPC:      r.idx = CSR_IDX_W'(5);
            CSR_MCAUSE:    r.idx = CSR_IDX_W'(6);
            CSR_MTVAL:     r.idx = CSR_IDX_W'(7);
            CSR_MIP:       r.idx = CSR_IDX_W'(8);
            CSR_MVENDORID: r.idx = CSR_IDX_W'(9);
            CSR_MARCHID:   r.idx = CSR_IDX_W'(10);
            CSR_MIMPID:    r.idx = CSR_IDX_W'(11);
            CSR_MHARTID:   r.idx = CSR_IDX_W'(12);
            default:       r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // The top two address bits encode read-only in the privileged address space.
    function automatic logic csr_is_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_access_unit_alu.sv
// Combinational Zicsr modify step: new CSR value and whether the instruction writes at all.
module csr_access_unit_alu
    import csr_access_unit_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] op_val,
    output logic [XLEN-1:0] new_val,
    output logic            do_write
);

    // funct3[1:0] selects the operation; funct3[2] only picks the operand source upstream.
    always_comb begin
        new_val  = old_val;
        do_write = 1'b0;
        case (funct3[1:0])
            2'b01: begin
                new_val  = op_val;
                do_write = 1'b1;
            end
            2'b10: begin
                new_val  = old_val | op_val;
                do_write = (rs1_idx != 5'd0);
            end
            2'b11: begin
                new_val  = old_val & ~op_val;
                do_write = (rs1_idx != 5'd0);
            end
            default: begin
                new_val  = old_val;
                do_write = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Serialized read-modify-write engine for Zicsr instructions in front of the CSR file.
// Handshake: a transfer happens on a posedge where valid and ready are both high.
module csr_access_unit
    import csr_access_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_funct3,
    input  logic [11:0]          req_csr_addr,
    input  logic [4:0]           req_rs1_idx,
    input  logic [XLEN-1:0]      req_rs1_val,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [XLEN-1:0]      rsp_rdata,
    output logic                 rsp_illegal,
    output logic [CSR_IDX_W-1:0] csr_raddr,
    input  logic [XLEN-1:0]      csr_rdata,
    output logic [CSR_IDX_W-1:0] csr_waddr,
    output logic [XLEN-1:0]      csr_wdata,
    output logic                 csr_web,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e          state;
    logic [2:0]      funct3_q;
    logic [11:0]     addr_q;
    logic [4:0]      rs1_idx_q;
    logic [XLEN-1:0] op_q;
    logic [XLEN-1:0] old_q;
    logic            illegal_q;

    logic [XLEN-1:0] new_val;
    logic            do_write;
    logic            legal;
    csr_idx_t        map;

    assign fsm_state = state;
    assign map       = csr_index(addr_q);
    assign legal     = map.valid && (funct3_q[1:0] != 2'b00) &&
                       !(csr_is_ro(addr_q) && do_write);

    csr_access_unit_alu u_alu (
        .funct3   (funct3_q),
        .rs1_idx  (rs1_idx_q),
        .old_val  (csr_rdata),
        .op_val   (op_q),
        .new_val  (new_val),
        .do_write (do_write)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_illegal <= 1'b0;
            csr_raddr   <= '0;
            csr_waddr   <= '0;
            csr_wdata   <= '0;
            csr_web     <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            rs1_idx_q   <= '0;
            op_q        <= '0;
            old_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        addr_q    <= req_csr_addr;
                        rs1_idx_q <= req_rs1_idx;
                        op_q      <= req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_val;
                        csr_raddr <= csr_index(req_csr_addr).idx;
                        req_ready <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    old_q     <= csr_rdata;
                    illegal_q <= !legal;
                    csr_web   <= legal && do_write;
                    csr_waddr <= map.idx;
                    csr_wdata <= new_val;
                    state     <= WRITE;
                end
                WRITE: begin
                    csr_web     <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= illegal_q ? '0 : old_q;
                    rsp_illegal <= illegal_q;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed and randomized Zicsr transactions against a behavioural CSR file and reference map.
module tb_csr_access_unit;
    import csr_access_unit_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_funct3;
    logic [11:0]          req_csr_addr;
    logic [4:0]           req_rs1_idx;
    logic [XLEN-1:0]      req_rs1_val;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [XLEN-1:0]      rsp_rdata;
    logic                 rsp_illegal;
    logic [CSR_IDX_W-1:0] csr_raddr;
    logic [XLEN-1:0]      csr_rdata;
    logic [CSR_IDX_W-1:0] csr_waddr;
    logic [XLEN-1:0]      csr_wdata;
    logic                 csr_web;
    logic [1:0]           fsm_state;

    csr_access_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_csr_addr (req_csr_addr),
        .req_rs1_idx  (req_rs1_idx),
        .req_rs1_val  (req_rs1_val),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_illegal  (rsp_illegal),
        .csr_raddr    (csr_raddr),
        .csr_rdata    (csr_rdata),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .csr_web      (csr_web),
        .fsm_state    (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural CSR file: combinational read, write on posedge
    logic [XLEN-1:0] file_mem [0:15];
    assign csr_rdata = file_mem[csr_raddr];
    always @(posedge clk) begin
        if (csr_web) file_mem[csr_waddr] <= csr_wdata;
    end

    // reference architectural state, keyed by 12-bit address
    logic [XLEN-1:0] ref_mem [logic [11:0]];
    logic [XLEN:0]   exp_q [$];

    int n_assert = 0;
    int n_fail   = 0;
    int web_cnt  = 0;
    logic [XLEN-1:0] web_wdata;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // write-enable monitor: every pulse must fall inside WRITE
    always @(negedge clk) begin
        if (csr_web === 1'b1) begin
            web_cnt++;
            web_wdata = csr_wdata;
            chk("web_only_in_write", {62'd0, fsm_state}, 64'd2);
        end
    end

    task automatic do_op(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                         input logic [XLEN-1:0] val, input int hold);
        logic [XLEN-1:0] op, old, nv, held;
        logic [XLEN:0]   exp;
        bit impl, dw, legal;
        int lat, guard;
        impl  = ref_mem.exists(addr);
        old   = impl ? ref_mem[addr] : '0;
        op    = f3[2] ? {59'd0, idx} : val;
        dw    = (f3[1:0] == 2'b01) || ((f3[1:0] != 2'b00) && (idx != 5'd0));
        legal = impl && (f3[1:0] != 2'b00) && !((addr[11:10] == 2'b11) && dw);
        case (f3[1:0])
            2'b01:   nv = op;
            2'b10:   nv = old | op;
            2'b11:   nv = old & ~op;
            default: nv = old;
        endcase
        exp_q.push_back({!legal, legal ? old : {XLEN{1'b0}}});
        if (legal && dw) ref_mem[addr] = nv;

        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_timeout", {63'd0, req_ready}, 64'd1);
        web_cnt      = 0;
        req_valid    = 1'b1;
        req_funct3   = f3;
        req_csr_addr = addr;
        req_rs1_idx  = idx;
        req_rs1_val  = val;
        rsp_ready    = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 8) begin
            chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        // accept edge plus two more edges
        chk("latency", 64'(lat), 64'd2);
        if (rsp_valid) begin
            held = rsp_rdata;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
                chk("hold_rdata", rsp_rdata, held);
                chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
            end
            exp = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, exp[XLEN-1:0]);
            chk("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, exp[XLEN]});
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("rsp_drop", {63'd0, rsp_valid}, 64'd0);
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("req_ready_back", {63'd0, req_ready}, 64'd1);
        end else begin
            void'(exp_q.pop_front());
        end
        chk("web_count", 64'(web_cnt), (legal && dw) ? 64'd1 : 64'd0);
        if (legal && dw) chk("web_wdata", web_wdata, nv);
        if (impl) chk("csr_file", file_mem[csr_index(addr).idx], ref_mem[addr]);
    endtask

    logic [2:0]  f3_tab   [0:7];
    logic [11:0] addr_tab [0:7];

    initial begin
        logic [CSR_IDX_W-1:0] slot;
        for (int i = 0; i < 16; i++) file_mem[i] = '0;
        ref_mem[12'h300] = '0; ref_mem[12'h301] = '0; ref_mem[12'h304] = '0;
        ref_mem[12'h305] = '0; ref_mem[12'h340] = '0; ref_mem[12'h341] = '0;
        ref_mem[12'h342] = '0; ref_mem[12'h343] = '0; ref_mem[12'h344] = '0;
        ref_mem[12'hF11] = '0; ref_mem[12'hF12] = '0; ref_mem[12'hF13] = '0;
        ref_mem[12'hF14] = '0;
        f3_tab   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111, 3'b000, 3'b100};
        addr_tab = '{12'h300, 12'h305, 12'h340, 12'h341, 12'hF11, 12'h7C0, 12'h343, 12'h301};

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_funct3 = '0; req_csr_addr = '0; req_rs1_idx = '0; req_rs1_val = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_illegal", {63'd0, rsp_illegal}, 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_web", {63'd0, csr_web}, 64'd0);
        chk("rst_raddr", 64'(csr_raddr), 64'd0);
        chk("rst_waddr", 64'(csr_waddr), 64'd0);
        chk("rst_wdata", csr_wdata, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_state", {62'd0, fsm_state}, 64'd0);

        do_op(3'b001, 12'h340, 5'd1, 64'h0000_0000_DEAD_BEEF, 0);
        do_op(3'b010, 12'h340, 5'd2, 64'h0000_0000_0000_00F0, 0);
        do_op(3'b011, 12'h340, 5'd3, 64'h0000_0000_0000_000F, 0);
        do_op(3'b010, 12'hF14, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_op(3'b101, 12'hF12, 5'd5, 64'd0, 0);
        do_op(3'b001, 12'h7C0, 5'd4, 64'h1234, 0);
        do_op(3'b100, 12'h340, 5'd4, 64'h1234, 0);
        do_op(3'b110, 12'h300, 5'd8, 64'd0, 5);
        do_op(3'b111, 12'h300, 5'd8, 64'd0, 0);
        do_op(3'b101, 12'h305, 5'd31, 64'd0, 2);
        do_op(3'b001, 12'h301, 5'd7, 64'h8000_0000_0014_1101, 0);

        for (int n = 0; n < 10; n++) begin
            do_op(f3_tab[$urandom_range(0, 7)], addr_tab[$urandom_range(0, 7)],
                  5'($urandom_range(0, 31)), {$urandom, $urandom}, $urandom_range(0, 2));
        end

        // reset during WRITE aborts the pending write
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h341;
        req_rs1_idx = 5'd9; req_rs1_val = 64'hCAFE_F00D_0BAD_1DEA; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_web_before", {63'd0, csr_web}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_web_drop", {63'd0, csr_web}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        slot = csr_index(12'h341).idx;
        chk("abort_csr_unchanged", file_mem[slot], ref_mem[12'h341]);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
        chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("abort_state", {62'd0, fsm_state}, 64'd0);

        do_op(3'b010, 12'h341, 5'd0, 64'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
